// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, cause codes,
// mstatus/mie bit positions, bus widths and the sequencer state encoding.
package trap_ctrl_pkg;

  localparam int unsigned REG_BUS_W  = 32;
  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Low four bits of mcause; the interrupt flag is carried separately.
  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_ECALL   = 4'd11;
  localparam logic [3:0] EXC_EBREAK  = 4'd3;
  localparam logic [3:0] IRQ_EXT     = 4'd11;
  localparam logic [3:0] IRQ_SOFT    = 4'd3;
  localparam logic [3:0] IRQ_TCMP    = 4'd7;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned MIE_MEIE = 11;
  localparam int unsigned MIE_MSIE = 3;
  localparam int unsigned MIE_MTIE = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W_MEPC    = 3'd1,
    ST_W_MCAUSE  = 3'd2,
    ST_W_MSTATUS = 3'd3,
    ST_R_MTVEC   = 3'd4,
    ST_M_MSTATUS = 3'd5,
    ST_R_MEPC    = 3'd6,
    ST_JUMP      = 3'd7
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl_prio.sv
// Fixed-priority selector over synchronous exceptions and enabled machine
// interrupts; produces a valid flag, an interrupt flag and the cause code.
module trap_prio
  import trap_ctrl_pkg::*;
(
  input  logic       inst_err_i,
  input  logic       ecall_i,
  input  logic       ebreak_i,
  input  logic       irq_ext_i,
  input  logic       irq_soft_i,
  input  logic       irq_tcmp_i,
  input  logic       mie_glb_i,
  input  logic       en_ext_i,
  input  logic       en_soft_i,
  input  logic       en_tcmp_i,
  output logic       valid_o,
  output logic       irq_o,
  output logic [3:0] code_o
);

  always_comb begin
    valid_o = 1'b1;
    irq_o   = 1'b0;
    code_o  = '0;
    if (inst_err_i) begin
      code_o = EXC_ILLEGAL;
    end else if (ecall_i) begin
      code_o = EXC_ECALL;
    end else if (ebreak_i) begin
      code_o = EXC_EBREAK;
    end else if (mie_glb_i && en_ext_i && irq_ext_i) begin
      irq_o  = 1'b1;
      code_o = IRQ_EXT;
    end else if (mie_glb_i && en_soft_i && irq_soft_i) begin
      irq_o  = 1'b1;
      code_o = IRQ_SOFT;
    end else if (mie_glb_i && en_tcmp_i && irq_tcmp_i) begin
      irq_o  = 1'b1;
      code_o = IRQ_TCMP;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: trap entry (mepc, mcause, mstatus, mtvec read) and mret
// through the single CSR port. Build macro TRAP_VECTOR_EN enables vectored mtvec.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = REG_BUS_W,
  parameter int unsigned CSR_AW = CSR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ecall_i,
  input  logic              ebreak_i,
  input  logic              inst_err_i,
  input  logic              mret_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic              irq_ext_i,
  input  logic              irq_soft_i,
  input  logic              irq_tcmp_i,
  input  logic [XLEN-1:0]   mstatus_i,
  input  logic [XLEN-1:0]   mie_i,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic              hold_o,
  output logic              jump_o,
  output logic [XLEN-1:0]   jump_addr_o,
  output logic              trap_in_o
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [3:0]      code_q, code_d;
  logic            irq_q, irq_d;

  logic            ev_valid, ev_irq;
  logic [3:0]      ev_code;
  logic            busy;
  logic [XLEN-1:0] ms_new;
  logic            unused_bits;

  assign unused_bits = &{1'b0, mie_i, csr_rdata_i[1:0]};

  trap_prio u_prio (
    .inst_err_i (inst_err_i),
    .ecall_i    (ecall_i),
    .ebreak_i   (ebreak_i),
    .irq_ext_i  (irq_ext_i),
    .irq_soft_i (irq_soft_i),
    .irq_tcmp_i (irq_tcmp_i),
    .mie_glb_i  (mstatus_i[MSTATUS_MIE]),
    .en_ext_i   (mie_i[MIE_MEIE]),
    .en_soft_i  (mie_i[MIE_MSIE]),
    .en_tcmp_i  (mie_i[MIE_MTIE]),
    .valid_o    (ev_valid),
    .irq_o      (ev_irq),
    .code_o     (ev_code)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    code_d      = code_q;
    irq_d       = irq_q;
    busy        = (state_q != ST_IDLE);
    ms_new      = mstatus_i;
    csr_we_o    = 1'b0;
    csr_wdata_o = '0;
    csr_addr_o  = '0;
    jump_o      = 1'b0;
    jump_addr_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Exceptions outrank mret; mret outranks interrupts, which stay
        // pending and are re-evaluated once the mret jump completes.
        if (rst_n && ev_valid && !(ev_irq && mret_i)) begin
          busy    = 1'b1;
          state_d = ST_W_MEPC;
          pc_d    = ex_pc_i;
          irq_d   = ev_irq;
          code_d  = ev_code;
        end else if (rst_n && mret_i) begin
          busy    = 1'b1;
          state_d = ST_M_MSTATUS;
        end
      end
      ST_W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MEPC);
        csr_wdata_o = pc_q;
        state_d     = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MCAUSE);
        csr_wdata_o = {irq_q, {(XLEN-5){1'b0}}, code_q};
        state_d     = ST_W_MSTATUS;
      end
      ST_W_MSTATUS: begin
        ms_new[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
        ms_new[MSTATUS_MIE]                   = 1'b0;
        ms_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MSTATUS);
        csr_wdata_o = ms_new;
        state_d     = ST_R_MTVEC;
      end
      ST_R_MTVEC: begin
        csr_addr_o = CSR_AW'(CSR_MTVEC);
        target_d   = {csr_rdata_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTOR_EN
        if (irq_q && (csr_rdata_i[1:0] == 2'b01)) begin
          target_d = {csr_rdata_i[XLEN-1:2], 2'b00}
                   + {{(XLEN-6){1'b0}}, code_q, 2'b00};
        end
`endif
        state_d = ST_JUMP;
      end
      ST_M_MSTATUS: begin
        ms_new[MSTATUS_MIE]                   = mstatus_i[MSTATUS_MPIE];
        ms_new[MSTATUS_MPIE]                  = 1'b1;
        ms_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MSTATUS);
        csr_wdata_o = ms_new;
        state_d     = ST_R_MEPC;
      end
      ST_R_MEPC: begin
        csr_addr_o = CSR_AW'(CSR_MEPC);
        target_d   = {csr_rdata_i[XLEN-1:2], 2'b00};
        state_d    = ST_JUMP;
      end
      ST_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = target_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hold_o    = busy;
  assign trap_in_o = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      target_q <= '0;
      code_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      code_q   <= code_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a reference model predicts CSR writes and
// jumps per event; a monitor pops and compares whenever the DUT writes or jumps.
module tb_trap_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ecall_i = 1'b0, ebreak_i = 1'b0, inst_err_i = 1'b0, mret_i = 1'b0;
  logic irq_ext_i = 1'b0, irq_soft_i = 1'b0, irq_tcmp_i = 1'b0;
  logic [31:0] ex_pc_i = '0;
  logic [31:0] mie_r = '0;
  logic [31:0] csr_rdata;
  logic [31:0] csr_wdata_o, jump_addr_o;
  logic [11:0] csr_addr_o;
  logic        csr_we_o, hold_o, jump_o, trap_in_o;

  // Environment CSR file (written by the DUT, or by the bench acting as handler)
  logic [31:0] env_ms = '0, env_tv = '0, env_ep = '0, env_mc = '0;
  logic        host_we = 1'b0;
  logic [31:0] h_ms = '0, h_tv = '0, h_ep = '0;

  // Reference model shadow state
  logic [31:0] m_ms = '0, m_tv = '0, m_ep = '0;

  int unsigned cyc = 0;
  int unsigned n_checks = 0, n_pass = 0;

  typedef struct {
    bit          jmp;
    int unsigned cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  trap_ctrl #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ecall_i     (ecall_i),
    .ebreak_i    (ebreak_i),
    .inst_err_i  (inst_err_i),
    .mret_i      (mret_i),
    .ex_pc_i     (ex_pc_i),
    .irq_ext_i   (irq_ext_i),
    .irq_soft_i  (irq_soft_i),
    .irq_tcmp_i  (irq_tcmp_i),
    .mstatus_i   (env_ms),
    .mie_i       (mie_r),
    .csr_rdata_i (csr_rdata),
    .csr_wdata_o (csr_wdata_o),
    .csr_we_o    (csr_we_o),
    .csr_addr_o  (csr_addr_o),
    .hold_o      (hold_o),
    .jump_o      (jump_o),
    .jump_addr_o (jump_addr_o),
    .trap_in_o   (trap_in_o)
  );

  always_comb begin
    case (csr_addr_o)
      12'h300: csr_rdata = env_ms;
      12'h305: csr_rdata = env_tv;
      12'h341: csr_rdata = env_ep;
      12'h342: csr_rdata = env_mc;
      default: csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (host_we) begin
      env_ms <= h_ms;
      env_tv <= h_tv;
      env_ep <= h_ep;
    end else if (csr_we_o) begin
      case (csr_addr_o)
        12'h300: env_ms <= csr_wdata_o;
        12'h305: env_tv <= csr_wdata_o;
        12'h341: env_ep <= csr_wdata_o;
        12'h342: env_mc <= csr_wdata_o;
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every DUT write or jump must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (csr_we_o || jump_o)) begin
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_output: got we=%0b jump=%0b addr=%0h required none (cycle %0d)",
                 csr_we_o, jump_o, csr_addr_o, cyc);
      end else begin
        e = sbq.pop_front();
        chk("out_kind", {63'b0, jump_o}, {63'b0, e.jmp});
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
        if (e.jmp) begin
          chk("jump_addr", 64'(jump_addr_o), 64'(e.addr));
          chk("hold_at_jump", {63'b0, hold_o}, 64'd1);
          chk("trap_in_at_jump", {63'b0, trap_in_o}, 64'd1);
        end else begin
          chk("csr_addr", 64'(csr_addr_o), 64'(e.addr));
          chk("csr_wdata", 64'(csr_wdata_o), 64'(e.data));
        end
      end
    end
  end

  function automatic logic [31:0] ms_after_trap(input logic [31:0] ms);
    logic [31:0] r;
    r = (ms & ~32'h0000_1888) | 32'h0000_1800;
    if (ms[3]) r = r | 32'h0000_0080;
    return r;
  endfunction

  function automatic logic [31:0] ms_after_mret(input logic [31:0] ms);
    logic [31:0] r;
    r = (ms & ~32'h0000_1888) | 32'h0000_1880;
    if (ms[7]) r = r | 32'h0000_0008;
    return r;
  endfunction

  // kind: 0 nothing, 1 trap entry, 2 mret
  function automatic void predict(output int kind, output logic [31:0] cause);
    bit          en[6];
    logic [31:0] cs[6];
    en[0] = inst_err_i; cs[0] = 32'd2;
    en[1] = ecall_i;    cs[1] = 32'd11;
    en[2] = ebreak_i;   cs[2] = 32'd3;
    en[3] = m_ms[3] && mie_r[11] && irq_ext_i;  cs[3] = 32'h8000_000B;
    en[4] = m_ms[3] && mie_r[3]  && irq_soft_i; cs[4] = 32'h8000_0003;
    en[5] = m_ms[3] && mie_r[7]  && irq_tcmp_i; cs[5] = 32'h8000_0007;
    kind = 0;
    cause = '0;
    for (int i = 0; i < 3; i++)
      if (kind == 0 && en[i]) begin kind = 1; cause = cs[i]; end
    if (kind == 0 && mret_i) kind = 2;
    for (int i = 3; i < 6; i++)
      if (kind == 0 && en[i]) begin kind = 1; cause = cs[i]; end
  endfunction

  task automatic host_set(input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
    h_ms = ms; h_tv = tv; h_ep = ep; host_we = 1'b1;
    @(posedge clk); #1;
    host_we = 1'b0;
    m_ms = ms; m_tv = tv; m_ep = ep;
  endtask

  // Called at posedge+1 with the DUT idle and inputs applied. Runs sequences
  // until the model predicts nothing; inj >= 0 pulses ecall that many cycles
  // into the first sequence (must be ignored).
  task automatic run_seq(input int inj);
    int          kind, len;
    logic [31:0] cause, tgt;
    int unsigned c;
    for (int it = 0; it < 4; it++) begin
      predict(kind, cause);
      c = cyc;
      #1;
      chk("hold_detect", {63'b0, hold_o}, {63'b0, kind != 0});
      chk("trap_in_detect", {63'b0, trap_in_o}, {63'b0, kind != 0});
      if (kind == 0) return;
      if (kind == 1) begin
        tgt = m_tv & ~32'h3;
`ifdef TRAP_VECTOR_EN
        if (cause[31] && m_tv[1:0] == 2'b01) tgt = tgt + 4 * (cause & 32'hF);
`endif
        sbq.push_back('{1'b0, c + 1, 32'h341, ex_pc_i});
        sbq.push_back('{1'b0, c + 2, 32'h342, cause});
        sbq.push_back('{1'b0, c + 3, 32'h300, ms_after_trap(m_ms)});
        sbq.push_back('{1'b1, c + 5, tgt, 32'h0});
        m_ep = ex_pc_i;
        m_ms = ms_after_trap(m_ms);
        len = 5;
      end else begin
        sbq.push_back('{1'b0, c + 1, 32'h300, ms_after_mret(m_ms)});
        sbq.push_back('{1'b1, c + 3, m_ep & ~32'h3, 32'h0});
        m_ms = ms_after_mret(m_ms);
        len = 3;
      end
      @(posedge clk); #1;
      ecall_i = 1'b0; ebreak_i = 1'b0; inst_err_i = 1'b0; mret_i = 1'b0;
      for (int k = 0; k < len; k++) begin
        ecall_i = (it == 0 && k == inj);
        @(posedge clk); #1;
        ecall_i = 1'b0;
      end
    end
    n_checks++;
    $display("FAIL seq_bound: got more than 4 back-to-back sequences required fewer");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", {63'b0, hold_o}, 64'd0);
    chk("rst_trap_in", {63'b0, trap_in_o}, 64'd0);
    chk("rst_jump", {63'b0, jump_o}, 64'd0);
    chk("rst_we", {63'b0, csr_we_o}, 64'd0);
    chk("rst_addr", 64'(csr_addr_o), 64'd0);
    chk("rst_wdata", 64'(csr_wdata_o), 64'd0);
    chk("rst_jaddr", 64'(jump_addr_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ecall at 0x100, mstatus 0x88, mtvec 0x200
    mie_r = '0;
    host_set(32'h88, 32'h200, 32'h0);
    ex_pc_i = 32'h100; ecall_i = 1'b1;
    run_seq(-1);

    // timer pending but globally masked, then unmasked
    host_set(32'h0, 32'h200, 32'h0);
    mie_r = 32'h80; irq_tcmp_i = 1'b1; ex_pc_i = 32'h120;
    run_seq(-1);
    repeat (3) @(posedge clk);
    #1;
    host_set(32'h8, 32'h200, m_ep);
    run_seq(-1);
    irq_tcmp_i = 1'b0;

    // ext + timer together: ext first, timer after handler re-enables MIE
    mie_r = 32'h880;
    host_set(32'h8, 32'h240, m_ep);
    irq_ext_i = 1'b1; irq_tcmp_i = 1'b1; ex_pc_i = 32'h140;
    run_seq(-1);
    irq_ext_i = 1'b0;
    ex_pc_i = 32'h144;
    host_set(m_ms | 32'h8, m_tv, m_ep);
    run_seq(-1);
    irq_tcmp_i = 1'b0;

    // mret with mstatus 0x1880, mepc 0x104
    mie_r = '0;
    host_set(32'h1880, 32'h200, 32'h104);
    mret_i = 1'b1;
    run_seq(-1);

    // ecall beats simultaneous mret
    host_set(32'h1880, 32'h200, 32'h104);
    ecall_i = 1'b1; mret_i = 1'b1; ex_pc_i = 32'h300;
    run_seq(-1);

    // mret beats soft irq; irq taken right after the mret jump
    mie_r = 32'h8;
    host_set(32'h1880, 32'h280, 32'h400);
    irq_soft_i = 1'b1; mret_i = 1'b1; ex_pc_i = 32'h500;
    run_seq(-1);
    irq_soft_i = 1'b0;

    // sync pulses arriving mid-sequence and in the jump cycle are ignored
    mie_r = '0;
    host_set(32'h0, 32'h240, 32'h0);
    ebreak_i = 1'b1; ex_pc_i = 32'h600;
    run_seq(1);
    inst_err_i = 1'b1; ex_pc_i = 32'h604;
    run_seq(4);

    // reset during W_MCAUSE
    host_set(32'h88, 32'h200, 32'h0);
    ex_pc_i = 32'h700; ecall_i = 1'b1;
    c = cyc;
    #1;
    chk("rst_seq_hold", {63'b0, hold_o}, 64'd1);
    sbq.push_back('{1'b0, c + 1, 32'h341, 32'h700});
    @(posedge clk); #1;
    ecall_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_hold", {63'b0, hold_o}, 64'd0);
    chk("midrst_we", {63'b0, csr_we_o}, 64'd0);
    chk("midrst_addr", 64'(csr_addr_o), 64'd0);
    chk("midrst_jump", {63'b0, jump_o}, 64'd0);
    chk("midrst_trap_in", {63'b0, trap_in_o}, 64'd0);
    m_ep = 32'h700;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_seq(-1);
    ex_pc_i = 32'h704; ecall_i = 1'b1;
    run_seq(-1);

    // vectored mtvec: soft irq vs ecall
    mie_r = 32'h8;
    host_set(32'h8, 32'h201, 32'h0);
    irq_soft_i = 1'b1; ex_pc_i = 32'h800;
    run_seq(-1);
    irq_soft_i = 1'b0;
    host_set(32'h8, 32'h201, 32'h0);
    ecall_i = 1'b1; ex_pc_i = 32'h804;
    run_seq(-1);

    // randomized events
    for (int n = 0; n < 40; n++) begin
      irq_ext_i = 1'b0; irq_soft_i = 1'b0; irq_tcmp_i = 1'b0;
      mie_r = $urandom & 32'h888;
      host_set($urandom & 32'h1888, ($urandom & 32'hFFF0) | 32'($urandom_range(0, 1)),
               $urandom & ~32'h3);
      ex_pc_i    = $urandom & ~32'h3;
      inst_err_i = ($urandom_range(0, 5) == 0);
      ecall_i    = ($urandom_range(0, 3) == 0);
      ebreak_i   = ($urandom_range(0, 3) == 0);
      mret_i     = ($urandom_range(0, 2) == 0);
      irq_ext_i  = ($urandom_range(0, 2) == 0);
      irq_soft_i = ($urandom_range(0, 2) == 0);
      irq_tcmp_i = ($urandom_range(0, 2) == 0);
      run_seq(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1);
      irq_ext_i = 1'b0; irq_soft_i = 1'b0; irq_tcmp_i = 1'b0;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
